// File: rtl/brq_pkg.sv
// brq_pkg: shared types and limits for the instruction-bus arbiter.
//   host_id_t           - 1-bit requester identifier (IFU prefetch or auxiliary fetch agent)
//   MaxOutstandingLimit - largest supported number of granted-but-unanswered transactions
package brq_pkg;

    typedef enum logic {
        HOST_IFU = 1'b0,
        HOST_AUX = 1'b1
    } host_id_t;

    localparam int unsigned MaxOutstandingLimit = 4;

endpackage

// File: rtl/brq_owner_fifo.sv
// brq_owner_fifo: small synchronous FIFO of requester IDs, one entry per outstanding
// transaction, used to route each response back to the requester that issued it.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   push_i        - enqueue push_id_i (ignored when full)
//   push_id_i     - owner of the transaction being granted
//   pop_i         - dequeue the head (ignored when empty)
//   head_o        - owner of the oldest outstanding transaction
//   full_o        - Depth entries held
//   empty_o       - no entries held
module brq_owner_fifo
    import brq_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  host_id_t push_id_i,
    input  logic     pop_i,
    output host_id_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    // A single-entry FIFO still needs a 1-bit pointer that simply never moves.
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = host_id_t'(mem_q[rd_ptr_q]);

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/brq_instr_bus_arb.sv
// brq_instr_bus_arb: two-requester arbiter for the single instruction memory port.
// Requester 0 is the IFU prefetch buffer, requester 1 a secondary fetch agent. Address
// phases are serialised round-robin onto one req/gnt/rvalid bus; the owner of every
// outstanding transaction is queued so each response returns only to its issuer.
// Ports:
//   clk_i, rst_i    - clock, asynchronous active-high reset
//   host_req_i      - per-requester address-phase request
//   host_addr_i     - per-requester word address
//   host_gnt_o      - per-requester grant (combinational from bus_gnt_i)
//   host_rvalid_o   - per-requester response valid (combinational from bus_rvalid_i)
//   host_rdata_o    - shared response data, qualified by host_rvalid_o
//   host_err_o      - shared response error, qualified by host_rvalid_o
//   bus_req_o/bus_addr_o/bus_gnt_i              - downstream address phase
//   bus_rvalid_i/bus_rdata_i/bus_err_i          - downstream response phase
//   proto_err_o     - pulse on a response with nothing outstanding
//   busy_o          - at least one transaction outstanding
module brq_instr_bus_arb
    import brq_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned ResetGrantPtr  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       host_req_i,
    input  logic [1:0][31:0] host_addr_i,
    output logic [1:0]       host_gnt_o,
    output logic [1:0]       host_rvalid_o,
    output logic [31:0]      host_rdata_o,
    output logic             host_err_o,
    output logic             bus_req_o,
    output logic [31:0]      bus_addr_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [31:0]      bus_rdata_i,
    input  logic             bus_err_i,
    output logic             proto_err_o,
    output logic             busy_o
);

    host_id_t rr_ptr_q, rr_ptr_d;
    logic     lock_q, lock_d;
    host_id_t lock_id_q, lock_id_d;

    host_id_t sel;
    logic     grant;
    logic     resp;
    logic     fifo_full;
    logic     fifo_empty;
    host_id_t fifo_head;

    // Requester selection. A stalled address phase keeps its requester selected so the
    // downstream address stays stable until the grant.
    always_comb begin
        sel = rr_ptr_q;
        if (lock_q) begin
            sel = lock_id_q;
        end else begin
            case (host_req_i)
                2'b01:   sel = HOST_IFU;
                2'b10:   sel = HOST_AUX;
                default: sel = rr_ptr_q;
            endcase
        end
    end

    // Gated on the registered occupancy: a same-cycle pop does not re-open the request.
    assign bus_req_o  = host_req_i[sel] & ~fifo_full & ~rst_i;
    assign bus_addr_o = host_addr_i[sel];
    assign grant      = bus_req_o & bus_gnt_i;

    always_comb begin
        host_gnt_o      = '0;
        host_gnt_o[sel] = grant;
    end

    // Response routing to the owner at the head of the queue.
    assign resp = bus_rvalid_i & ~fifo_empty & ~rst_i;

    always_comb begin
        host_rvalid_o            = '0;
        host_rvalid_o[fifo_head] = resp;
    end

    assign host_rdata_o = bus_rdata_i;
    assign host_err_o   = bus_err_i;
    assign proto_err_o  = bus_rvalid_i & fifo_empty & ~rst_i;
    assign busy_o       = ~fifo_empty;

    // Priority and address-phase lock.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;

        if (grant) begin
            rr_ptr_d = host_id_t'(~sel);
            lock_d   = 1'b0;
        end else if (bus_req_o) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (lock_q && !host_req_i[lock_id_q]) begin
            // Locked requester withdrew its request: just release the lock.
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q  <= host_id_t'(ResetGrantPtr[0]);
            lock_q    <= 1'b0;
            lock_id_q <= HOST_IFU;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    brq_owner_fifo #(
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (grant),
        .push_id_i (sel),
        .pop_i     (resp),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule

// File: tb/tb_brq_instr_bus_arb.sv
// tb_brq_instr_bus_arb: directed stimulus with a queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_brq_instr_bus_arb;

    localparam int unsigned MAXO = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       host_req;
    logic [1:0][31:0] host_addr;
    logic [1:0]       host_gnt_o;
    logic [1:0]       host_rvalid_o;
    logic [31:0]      host_rdata_o;
    logic             host_err_o;
    logic             bus_req_o;
    logic [31:0]      bus_addr_o;
    logic             bus_gnt;
    logic             bus_rvalid;
    logic [31:0]      bus_rdata;
    logic             bus_err;
    logic             proto_err_o;
    logic             busy_o;

    always #5 clk = ~clk;

    brq_instr_bus_arb #(
        .MaxOutstanding (MAXO),
        .ResetGrantPtr  (0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .host_req_i    (host_req),
        .host_addr_i   (host_addr),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .bus_req_o     (bus_req_o),
        .bus_addr_o    (bus_addr_o),
        .bus_gnt_i     (bus_gnt),
        .bus_rvalid_i  (bus_rvalid),
        .bus_rdata_i   (bus_rdata),
        .bus_err_i     (bus_err),
        .proto_err_o   (proto_err_o),
        .busy_o        (busy_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding owners, current priority holder and the
    // requester whose address phase is waiting for a grant.
    int owners[$];
    int prio    = 0;
    bit held    = 0;
    int held_id = 0;

    always @(negedge clk) begin
        int         pick;
        logic       e_req;
        logic [1:0] e_gnt;
        logic [1:0] e_rv;
        logic       e_perr;
        if (rst) begin
            chk("rst bus_req", 32'(bus_req_o), 32'h0);
            chk("rst host_gnt", 32'(host_gnt_o), 32'h0);
            chk("rst host_rvalid", 32'(host_rvalid_o), 32'h0);
            chk("rst proto_err", 32'(proto_err_o), 32'h0);
            chk("rst busy", 32'(busy_o), 32'h0);
            owners.delete();
            prio = 0;
            held = 0;
        end else begin
            if (held) pick = held_id;
            else if (host_req == 2'b10) pick = 1;
            else if (host_req == 2'b01) pick = 0;
            else pick = prio;
            e_req = host_req[pick] && (owners.size() < MAXO);
            e_gnt = 2'b00;
            if (e_req && bus_gnt) e_gnt[pick] = 1'b1;
            e_rv = 2'b00;
            if (bus_rvalid && owners.size() > 0) e_rv[owners[0]] = 1'b1;
            e_perr = bus_rvalid && owners.size() == 0;

            chk("model bus_req", 32'(bus_req_o), 32'(e_req));
            if (e_req) chk("model bus_addr", bus_addr_o, host_addr[pick]);
            chk("model host_gnt", 32'(host_gnt_o), 32'(e_gnt));
            chk("model host_rvalid", 32'(host_rvalid_o), 32'(e_rv));
            if (e_rv != 2'b00) begin
                chk("model rdata", host_rdata_o, bus_rdata);
                chk("model err", 32'(host_err_o), 32'(bus_err));
            end
            chk("model proto_err", 32'(proto_err_o), 32'(e_perr));
            chk("model busy", 32'(busy_o), 32'(owners.size() > 0));

            if (e_rv != 2'b00) void'(owners.pop_front());
            if (e_gnt != 2'b00) begin
                owners.push_back(pick);
                prio = 1 - pick;
                held = 0;
            end else if (e_req) begin
                held    = 1;
                held_id = pick;
            end else if (held && !host_req[held_id]) begin
                held = 0;
            end
        end
    end

    task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic g, input logic rv, input logic [31:0] rd,
                         input logic er);
        @(posedge clk);
        #1;
        host_req     = req;
        host_addr[0] = a0;
        host_addr[1] = a1;
        bus_gnt      = g;
        bus_rvalid   = rv;
        bus_rdata    = rd;
        bus_err      = er;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        host_req   = 2'b00;
        host_addr  = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_err    = 1'b0;

        // Reset: three cycles, the last with requests, grant and rvalid all driven.
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        drive(2'b11, 32'h10, 32'h20, 1, 1, 0, 0);
        look();
        chk("reset masks bus_req", 32'(bus_req_o), 32'h0);
        chk("reset masks proto_err", 32'(proto_err_o), 32'h0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        look();
        chk("idle busy", 32'(busy_o), 32'h0);
        chk("idle host_gnt", 32'(host_gnt_o), 32'h0);

        // Solo fetch.
        drive(2'b01, 32'h0000_0080, 0, 1, 0, 0, 0);
        look();
        chk("solo gnt", 32'(host_gnt_o), 32'h1);
        chk("solo addr", bus_addr_o, 32'h0000_0080);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        drive(2'b00, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        look();
        chk("solo rvalid", 32'(host_rvalid_o), 32'h1);
        chk("solo rdata", host_rdata_o, 32'hDEAD_BEEF);

        // Contention: priority was handed to requester 1 by the solo grant.
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 1, (i > 0), 32'(i), 0);
            if (i == 0) begin
                look();
                chk("contention first gnt", 32'(host_gnt_o), 32'h2);
            end else if (i == 1) begin
                look();
                chk("contention second gnt", 32'(host_gnt_o), 32'h1);
                chk("contention first resp", 32'(host_rvalid_o), 32'h2);
            end
        end
        drive(2'b00, 0, 0, 0, 1, 32'h77, 0);
        look();
        chk("contention last resp", 32'(host_rvalid_o), 32'h2);

        // Stalled grant: requester 1 locked although priority now sits with 0.
        drive(2'b10, 0, 32'h1A11_0800, 0, 0, 0, 0);
        drive(2'b10, 0, 32'h1A11_0800, 0, 0, 0, 0);
        drive(2'b11, 32'h55, 32'h1A11_0800, 0, 0, 0, 0);
        drive(2'b11, 32'h55, 32'h1A11_0800, 0, 0, 0, 0);
        look();
        chk("stall addr held", bus_addr_o, 32'h1A11_0800);
        chk("stall no gnt", 32'(host_gnt_o), 32'h0);
        drive(2'b11, 32'h55, 32'h1A11_0800, 1, 0, 0, 0);
        look();
        chk("stall gnt to 1", 32'(host_gnt_o), 32'h2);

        // Error response for owner 1.
        drive(2'b00, 0, 0, 0, 1, 32'h0BAD, 1);
        look();
        chk("err rvalid", 32'(host_rvalid_o), 32'h2);
        chk("err flag", 32'(host_err_o), 32'h1);

        // Full throttle.
        drive(2'b01, 32'h100, 0, 1, 0, 0, 0);
        drive(2'b01, 32'h104, 0, 1, 0, 0, 0);
        drive(2'b01, 32'h108, 0, 1, 0, 0, 0);
        look();
        chk("full blocks req", 32'(bus_req_o), 32'h0);
        drive(2'b01, 32'h108, 0, 1, 0, 0, 0);
        drive(2'b01, 32'h108, 0, 1, 1, 32'hA1, 0);
        look();
        chk("full pop cycle req", 32'(bus_req_o), 32'h0);
        chk("full pop rvalid", 32'(host_rvalid_o), 32'h1);
        drive(2'b01, 32'h108, 0, 1, 0, 0, 0);
        look();
        chk("full resumes gnt", 32'(host_gnt_o), 32'h1);
        drive(2'b00, 0, 0, 0, 1, 32'hA2, 0);
        drive(2'b00, 0, 0, 0, 1, 32'hA3, 0);

        // Response with nothing outstanding.
        drive(2'b00, 0, 0, 0, 1, 32'hEE, 0);
        look();
        chk("proto pulse", 32'(proto_err_o), 32'h1);
        chk("proto no rvalid", 32'(host_rvalid_o), 32'h0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        look();
        chk("proto one cycle", 32'(proto_err_o), 32'h0);

        // Reset with a transaction outstanding, then a late response.
        drive(2'b01, 32'h200, 0, 1, 0, 0, 0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 1, 32'hCC, 0);
        rst = 1'b0;
        look();
        chk("late rvalid proto", 32'(proto_err_o), 32'h1);
        chk("late rvalid dropped", 32'(host_rvalid_o), 32'h0);

        drive(2'b00, 0, 0, 0, 0, 0, 0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        look();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brq_instr_bus_arb.md
# brq_instr_bus_arb

Two-requester arbiter for the core's single instruction memory port. Requester 0 is the IFU prefetch buffer; requester 1 is a secondary fetch agent such as a debug program-buffer loader or an I-cache refill engine. It serialises their address phases onto one req/gnt/rvalid bus and tracks the owner of every outstanding transaction. Each response is returned only to the requester that issued it.

## Interface
Parameters:
- MaxOutstanding, default 2: maximum granted-but-unanswered transactions; legal range 1..4.
- ResetGrantPtr, default 0: requester that holds round-robin priority after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- host_req_i  in  2  per-requester address-phase request.
- host_addr_i  in  2x32  per-requester word address.
- host_gnt_o  out  2  per-requester grant.
- host_rvalid_o  out  2  per-requester response valid.
- host_rdata_o  out  32  response data, shared by both requesters and qualified by host_rvalid_o.
- host_err_o  out  1  response bus error, qualified by host_rvalid_o.
- bus_req_o  out  1  downstream request.
- bus_addr_o  out  32  downstream address.
- bus_gnt_i  in  1  downstream grant.
- bus_rvalid_i  in  1  downstream response valid.
- bus_rdata_i  in  32  downstream response data.
- bus_err_i  in  1  downstream bus error; covers bus and PMP errors, which are ORed upstream.
- proto_err_o  out  1  one-cycle pulse when a response arrives with no transaction outstanding.
- busy_o  out  1  high when at least one transaction is outstanding.

## Operation
- State:
  - rr_ptr (1b): priority holder.
  - lock_q (1b) and lock_id_q (1b): an address phase is in progress.
  - Owner FIFO: MaxOutstanding entries of 1b each, with rd_ptr, wr_ptr and cnt. cnt is $clog2(MaxOutstanding+1) bits wide. Pointers wrap modulo MaxOutstanding.
- Selection:
  - If lock_q is set, sel = lock_id_q.
  - Otherwise, with a single requester, sel is that requester.
  - Otherwise, with both requesting, sel = rr_ptr.
- Gating:
  - full = (cnt == MaxOutstanding).
  - bus_req_o = host_req_i[sel] & ~full & ~rst_i.
  - bus_addr_o = host_addr_i[sel].
- Grant return:
  - host_gnt_o[sel] = bus_gnt_i & bus_req_o.
  - The other grant bit is 0.
- Lock:
  - Set lock_q and lock_id_q=sel when bus_req_o is high and bus_gnt_i is low.
  - Clear lock_q on the grant.
  - This holds the address stable, as the bus protocol requires.
  - If the locked requester drops its request, which is illegal, clear lock_q and take no other action.
- On a grant:
  - Push sel into the FIFO.
  - Set rr_ptr = ~sel, giving round-robin fairness.
- Response: when bus_rvalid_i is high and cnt > 0:
  - host_rvalid_o[fifo[rd_ptr]] = 1.
  - Pass rdata and err straight through.
  - Pop the FIFO.
- Response with nothing outstanding: when bus_rvalid_i is high and cnt == 0:
  - host_rvalid_o stays 0.
  - proto_err_o pulses.
  - State is unchanged.
- Push and pop in the same cycle: allowed. cnt is unchanged and both pointers advance.
- Push while full: impossible, because bus_req_o is masked.
- busy_o = (cnt != 0).

## Timing
- Zero-cycle combinational paths:
  - host_req_i to bus_req_o.
  - bus_gnt_i to host_gnt_o.
  - bus_rvalid_i to host_rvalid_o.
- No added latency on the request or response path.
- Values while rst_i is asserted and immediately after release:
  - rr_ptr=ResetGrantPtr, lock_q=0, cnt=0, pointers=0.
  - bus_req_o=0, host_gnt_o=0, host_rvalid_o=0, proto_err_o=0, busy_o=0.
- Reset mid-operation discards all outstanding ownership. Any late bus_rvalid_i after reset raises proto_err_o.
- When full, bus_req_o drops in the cycle cnt reaches MaxOutstanding. It can reassert in the cycle after a pop, or combinationally in the same cycle as a pop only if cnt has already decremented. Required behaviour: gate on the registered cnt, which costs at most one cycle of bandwidth.
- Sustained dual request with MaxOutstanding responses pipelined produces strictly alternating grants 0,1,0,1.

## Structure
- Place in brq_pkg:
  - a 1-bit requester-ID typedef (host_id_t, with HOST_IFU=0 and HOST_AUX=1);
  - a localparam for the maximum legal MaxOutstanding.
- One natural sub-module, brq_owner_fifo: a parameterised 1-bit-wide synchronous FIFO providing push, pop, head, full and empty.
- Select and grant logic lives in the top module.

## Test plan
- Reset then idle: rst_i=1 for 3 cycles, then released. Required: every output is 0, and busy_o stays 0 with no requests.
- Solo fetch:
  - Stimulus: host_req_i=2'b01, addr 0x0000_0080, bus_gnt_i=1 in the same cycle; bus_rvalid_i two cycles later with rdata 0xDEAD_BEEF.
  - Required: host_gnt_o=2'b01, then host_rvalid_o=2'b01 with rdata 0xDEAD_BEEF.
- Contention:
  - Stimulus: both requesters request continuously, with gnt=1 every cycle and rvalid one cycle later.
  - Required: grants alternate 0,1,0,1 and each response returns to its owner in issue order.
- Stalled grant:
  - Stimulus: req1 asserted at 0x1A11_0800 with gnt=0 for 4 cycles; req0 rises at cycle 2.
  - Required: bus_addr_o holds 0x1A11_0800 until the grant, and the grant goes to requester 1.
- Full throttle:
  - Stimulus: MaxOutstanding=2, two grants with no rvalid, then a third request.
  - Required: bus_req_o=0 until the first rvalid; after it, the request proceeds.
- Error paths:
  - Stimulus: rvalid with bus_err_i=1 for outstanding owner 1.
  - Required: host_rvalid_o=2'b10 and host_err_o=1.
  - Stimulus: rvalid with cnt=0.
  - Required: proto_err_o pulses for 1 cycle and host_rvalid_o=0.
